// File: rtl/muldiv_seq_pkg.sv
// Shared types, widths and operand-signedness helpers for the RV32M sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    // funct3 encoding of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // rs1 is treated as signed for these operations
    function automatic logic is_signed_a(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed for these operations
    function automatic logic is_signed_b(input op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Upper half of the funct3 space is divide/remainder
    function automatic logic is_div(input op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_seq_if;

    logic                       start;
    logic [2:0]                 funct3;
    logic [muldiv_pkg::XLEN-1:0] a;
    logic [muldiv_pkg::XLEN-1:0] b;
    logic                       flush;
    logic                       ready;
    logic                       busy;
    logic                       done;
    logic [muldiv_pkg::XLEN-1:0] result;

    modport master (
        output start, funct3, a, b, flush,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, funct3, a, b, flush,
        output ready, busy, done, result
    );

endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one shared 2*XLEN accumulator,
// shift-add multiply, restoring divide, sign fix-up, and IDLE-resolved fast paths.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus_if
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam int unsigned ACC_W = 2 * XLEN;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    op_e                 op_q, op_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                ready_q, busy_q, done_q;

    op_e                 req_op_c;
    logic                accept_c;
    logic                b_zero_c;
    logic                ovf_c;
    logic                fast_c;
    logic [XLEN-1:0]     fast_val_c;
    logic [XLEN:0]       mul_sum_c;
    logic [ACC_W-1:0]    mul_next_c;
    logic [XLEN:0]       div_diff_c;
    logic [ACC_W-1:0]    div_next_c;
    logic [ACC_W-1:0]    prod_c;
    logic [XLEN-1:0]     quo_c;
    logic [XLEN-1:0]     rem_c;
    logic [XLEN-1:0]     fix_val_c;

    assign req_op_c = op_e'(bus_if.funct3);
    assign accept_c = (state_q == ST_IDLE) && bus_if.start && !bus_if.flush;
    assign b_zero_c = (bus_if.b == '0);
    assign ovf_c    = (bus_if.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus_if.b == '1);

    // Divide-by-zero and signed-overflow results that need no iteration
    always_comb begin
        fast_c     = 1'b0;
        fast_val_c = '0;
        case (req_op_c)
            OP_DIV: begin
                if (b_zero_c) begin
                    fast_c     = 1'b1;
                    fast_val_c = '1;
                end else if (ovf_c) begin
                    fast_c     = 1'b1;
                    fast_val_c = bus_if.a;
                end
            end
            OP_DIVU: begin
                if (b_zero_c) begin
                    fast_c     = 1'b1;
                    fast_val_c = '1;
                end
            end
            OP_REM: begin
                if (b_zero_c) begin
                    fast_c     = 1'b1;
                    fast_val_c = bus_if.a;
                end else if (ovf_c) begin
                    fast_c     = 1'b1;
                    fast_val_c = '0;
                end
            end
            OP_REMU: begin
                if (b_zero_c) begin
                    fast_c     = 1'b1;
                    fast_val_c = bus_if.a;
                end
            end
            default: ;
        endcase
    end

    // Shift-add step: {hi, lo} with the multiplier consumed from lo[0]
    assign mul_sum_c  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next_c = {mul_sum_c, acc_q[XLEN-1:1]};

    // Restoring step: {rem, quo}; the shifted partial remainder is acc_q[ACC_W-1:XLEN-1]
    assign div_diff_c = acc_q[ACC_W-1:XLEN-1] - {1'b0, opb_q};
    assign div_next_c = div_diff_c[XLEN] ? {acc_q[ACC_W-2:0], 1'b0}
                                         : {div_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // Sign correction and output word selection
    assign prod_c = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_c  = acc_q[XLEN-1:0];
    assign rem_c  = acc_q[ACC_W-1:XLEN];

    always_comb begin
        fix_val_c = '0;
        case (op_q)
            OP_MUL:                       fix_val_c = prod_c[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val_c = prod_c[ACC_W-1:XLEN];
            OP_DIV, OP_DIVU:              fix_val_c = (sign_a_q ^ sign_b_q) ? -quo_c : quo_c;
            default:                      fix_val_c = sign_a_q ? -rem_c : rem_c;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_d  = req_op_c;
                    acc_d = {{XLEN{1'b0}}, bus_if.a};
                    opb_d = bus_if.b;
                    if (fast_c) begin
                        result_d = fast_val_c;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_PREP;
                    end
                end
            end
            ST_PREP: begin
                sign_a_d = is_signed_a(op_q) & acc_q[XLEN-1];
                sign_b_d = is_signed_b(op_q) & opb_q[XLEN-1];
                acc_d    = {{XLEN{1'b0}}, (sign_a_d ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0])};
                opb_d    = sign_b_d ? -opb_q : opb_q;
                cnt_d    = CNT_W'(XLEN);
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                acc_d = is_div(op_q) ? div_next_c : mul_next_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = fix_val_c;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pipeline kill abandons the operation without touching result
        if (bus_if.flush && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_q <= result_d;
            ready_q  <= (state_d == ST_IDLE);
            busy_q   <= (state_d == ST_PREP) || (state_d == ST_RUN) || (state_d == ST_FIX);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign bus_if.ready  = ready_q;
    assign bus_if.busy   = busy_q;
    assign bus_if.done   = done_q;
    assign bus_if.result = result_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multi-cycle sequencer for the RV32M multiply/divide operations. It sits beside the single-cycle ALU in the EX stage and accepts one operation at a time through a start/ready handshake. While an operation runs it drives a stall request to the pipeline. It returns a registered 32-bit result with a one-cycle `done` pulse.

## Interface
- XLEN, 32: operand and result width; the iteration count equals XLEN.
- clk  in  1  : the single clock. All state changes on its rising edge.
- rst_n  in  1  : reset. Asynchronous, active-low.
- start  in  1  : request strobe. Accepted only when ready=1.
- funct3  in  3  : operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  : rs1 operand, sampled on acceptance.
- b  in  XLEN  : rs2 operand, sampled on acceptance.
- flush  in  1  : pipeline kill. Aborts any operation in progress.
- ready  out  1  : high only in IDLE.
- busy  out  1  : stall request. High in PREP, RUN and FIX.
- done  out  1  : one-cycle pulse. result is valid in this cycle.
- result  out  XLEN  : registered result. Holds its value until the next accepted start.

## Operation
- States:
  - IDLE: accept a request on start & ready & !flush.
    - Fast-path operation: go to DONE.
    - Any other operation: go to PREP.
  - PREP: latch operand magnitudes and sign flags; load counter = XLEN; go to RUN.
  - RUN: perform one iteration per cycle and decrement the counter. On the cycle the counter reaches 1, go to FIX.
  - FIX: apply sign correction and select the output word into result; go to DONE.
  - DONE: assert done; go to IDLE.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: sign-agnostic; it uses the low word.
- Multiply: shift-add over unsigned magnitudes into a 2*XLEN product. If the operand signs differ, FIX two's-complement negates the full 2*XLEN product.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring shift-subtract on magnitudes, one quotient bit per RUN cycle.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- Fast paths resolve in IDLE and require no iteration:
  - b==0, DIV or DIVU: result = all ones.
  - b==0, REM or REMU: result = a.
  - DIV with a=0x80000000 and b=0xFFFFFFFF: result = 0x80000000.
  - REM with a=0x80000000 and b=0xFFFFFFFF: result = 0.
- Flush: in any state other than IDLE, the next state is IDLE. done is not pulsed and result is not updated. If flush and start are high in the same cycle, flush wins and start is ignored.
- start is ignored while ready=0. There is no queuing.
- Reset values: state IDLE, ready=1, busy=0, done=0, result=0, counter=0.

## Timing
- Normal operation with start accepted in cycle 0:
  - Cycle 1: PREP.
  - Cycles 2 to XLEN+1: RUN.
  - Cycle XLEN+2: FIX.
  - Cycle XLEN+3: done=1. For XLEN=32 this is cycle 35.
- busy is high from cycle 1 through XLEN+2. It is low in the done cycle, so the pipeline captures result as it advances.
- Fast path: done=1 in cycle 1. busy stays 0 throughout.
- The earliest next acceptance is the cycle after done, when ready=1 again.
- Every output is driven directly from a register or from the state decode. No output has a combinational path from the inputs.
- Reset asserted mid-operation forces IDLE immediately, without waiting for a clock edge.

## Structure
- Package `muldiv_pkg` holds:
  - the funct3 operation enum;
  - the state enum (IDLE, PREP, RUN, FIX, DONE);
  - the constant XLEN default;
  - a helper function `is_signed_a`/`is_signed_b` keyed on funct3.
- The block is a single module. It contains the FSM, a $clog2(XLEN+1)-bit counter, a 2*XLEN accumulator shared by multiply and divide, and the sign flags.
- No sub-module is needed. The shared accumulator is the only datapath.

## Test plan
- MUL with a=7, b=-3 (0xFFFFFFFD): result=0xFFFFFFEB, done in cycle 35, busy high in cycles 1–34.
- MULH with a=0x80000000, b=0x80000000: result=0x40000000. MULHU with a=0xFFFFFFFF, b=0xFFFFFFFF: result=0xFFFFFFFE.
- Signed divide with a=-7, b=2:
  - DIV: result=0xFFFFFFFD (-3).
  - REM: result=0xFFFFFFFF (-1).
  - DIVU with a=100, b=7: result=14.
- Fast paths, each with done in cycle 1 and busy never asserted:
  - DIV with b=0, a=5: result=0xFFFFFFFF.
  - REMU with b=0, a=5: result=5.
  - DIV with a=0x80000000, b=-1: result=0x80000000.
- Flush in cycle 10 of a DIVU: IDLE in cycle 11, no done pulse, result unchanged from its previous value.
- Handshake and reset:
  - start held high for 40 cycles: exactly one acceptance, and a second acceptance in cycle 36.
  - rst_n low mid-RUN: all outputs at their reset values immediately.
